exc_arbiter: RTL and testbench

- Writeback-stage exception/interrupt arbiter, directly upstream of the CSR unit.
- Collects per-instruction exception flags accumulated through IF/ID/EX/MEM and the CSR-provided interrupt state (lie/is/ie). Picks one event per committing instruction.
- Drives the CSR unit's is_exc/excode/esubcode/badvaddr/csr_pc/is_ertn/is_fetch_again inputs as registered one-cycle pulses.
- Runs a flush state machine that blocks commits until the CSR-driven redirect has taken effect.

---
 rtl/exc_arbiter_pkg.sv | 45 ++++
 rtl/exc_arbiter_if.sv | 38 +++
 rtl/exc_arbiter_prio_enc.sv | 70 +++++++
 rtl/exc_arbiter.sv | 110 +++++++++++
 tb/tb_exc_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_arbiter_pkg.sv
// Shared types and constants for the writeback exception/interrupt arbiter.
// Exception-source flags, LoongArch exception codes and FSM encodings live here.
package exc_arbiter_pkg;

  localparam int FLUSH_CYCLES_DEF = 2;

  // Field order is bit 13 down to bit 0, which is also the reporting priority.
  typedef struct packed {
    logic adef;
    logic tlbr_f;
    logic pif;
    logic ppi_f;
    logic ine;
    logic ipe;
    logic sys;
    logic brk;
    logic ale;
    logic adem;
    logic tlbr_m;
    logic pil;
    logic pis;
    logic pme;
  } exc_src_t;

  localparam logic [5:0] EXC_INT  = 6'h00;
  localparam logic [5:0] EXC_PIL  = 6'h01;
  localparam logic [5:0] EXC_PIS  = 6'h02;
  localparam logic [5:0] EXC_PIF  = 6'h03;
  localparam logic [5:0] EXC_PME  = 6'h04;
  localparam logic [5:0] EXC_PPI  = 6'h07;
  localparam logic [5:0] EXC_ADE  = 6'h08;
  localparam logic [5:0] EXC_ALE  = 6'h09;
  localparam logic [5:0] EXC_SYS  = 6'h0B;
  localparam logic [5:0] EXC_BRK  = 6'h0C;
  localparam logic [5:0] EXC_INE  = 6'h0D;
  localparam logic [5:0] EXC_IPE  = 6'h0E;
  localparam logic [5:0] EXC_TLBR = 6'h3F;

  localparam logic [8:0] ESUB_ADEF = 9'd0;
  localparam logic [8:0] ESUB_ADEM = 9'd1;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;
  typedef enum logic [1:0] {EV_NONE, EV_EXC, EV_ERTN, EV_REFETCH} event_t;

endpackage

// File: rtl/exc_arbiter_if.sv
// WB-stage-to-CSR bundle seen by the exception arbiter.
// master drives the WB/CSR-state side; slave is the arbiter itself.
interface exc_arbiter_if
  import exc_arbiter_pkg::*;
#(
  parameter int PC_W = 32
);
  logic            wb_valid;
  logic [PC_W-1:0] wb_pc;
  logic [PC_W-1:0] wb_badv;
  exc_src_t        wb_exc;
  logic            wb_is_ertn;
  logic            wb_refetch;
  logic [11:0]     lie;
  logic [11:0]     is;
  logic            ie;
  logic            commit_ok;
  logic            flush;
  logic            is_exc;
  logic [5:0]      excode;
  logic [8:0]      esubcode;
  logic [PC_W-1:0] badvaddr;
  logic [PC_W-1:0] csr_pc;
  logic            is_ertn;
  logic            is_fetch_again;

  modport master (
    output wb_valid, wb_pc, wb_badv, wb_exc, wb_is_ertn, wb_refetch, lie, is, ie,
    input  commit_ok, flush, is_exc, excode, esubcode, badvaddr, csr_pc, is_ertn,
           is_fetch_again
  );

  modport slave (
    input  wb_valid, wb_pc, wb_badv, wb_exc, wb_is_ertn, wb_refetch, lie, is, ie,
    output commit_ok, flush, is_exc, excode, esubcode, badvaddr, csr_pc, is_ertn,
           is_fetch_again
  );
endinterface

// File: rtl/exc_arbiter_prio_enc.sv
// Fixed-priority encoder: picks the single reportable event for the WB instruction
// and derives its excode, esubcode and BADV value.
module exc_prio_enc
  import exc_arbiter_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            i_int_pend,
  input  exc_src_t        i_exc,
  input  logic [PC_W-1:0] i_badv,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_hit,
  output logic [5:0]      o_excode,
  output logic [8:0]      o_esubcode,
  output logic [PC_W-1:0] o_badvaddr
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the chain infers a latch.
    o_hit      = i_int_pend | (|i_exc);
    o_excode   = EXC_INT;
    o_esubcode = '0;
    o_badvaddr = '0;
    if (i_int_pend) begin
      o_excode = EXC_INT;
    end else if (i_exc.adef) begin
      o_excode   = EXC_ADE;
      o_esubcode = ESUB_ADEF;
      o_badvaddr = i_pc;
    end else if (i_exc.tlbr_f) begin
      o_excode   = EXC_TLBR;
      o_badvaddr = i_pc;
    end else if (i_exc.pif) begin
      o_excode   = EXC_PIF;
      o_badvaddr = i_pc;
    end else if (i_exc.ppi_f) begin
      o_excode   = EXC_PPI;
      o_badvaddr = i_pc;
    end else if (i_exc.ine) begin
      o_excode = EXC_INE;
    end else if (i_exc.ipe) begin
      o_excode = EXC_IPE;
    end else if (i_exc.sys) begin
      o_excode = EXC_SYS;
    end else if (i_exc.brk) begin
      o_excode = EXC_BRK;
    end else if (i_exc.ale) begin
      o_excode   = EXC_ALE;
      o_badvaddr = i_badv;
    end else if (i_exc.adem) begin
      o_excode   = EXC_ADE;
      o_esubcode = ESUB_ADEM;
      o_badvaddr = i_badv;
    end else if (i_exc.tlbr_m) begin
      o_excode   = EXC_TLBR;
      o_badvaddr = i_badv;
    end else if (i_exc.pil) begin
      o_excode   = EXC_PIL;
      o_badvaddr = i_badv;
    end else if (i_exc.pis) begin
      o_excode   = EXC_PIS;
      o_badvaddr = i_badv;
    end else if (i_exc.pme) begin
      // Bit 0 is shared by PME and PPI-mem; MEM marks PPI-mem via the top BADV bit.
      o_excode   = i_badv[PC_W-1] ? EXC_PPI : EXC_PME;
      o_badvaddr = i_badv;
    end
  end

endmodule

// File: rtl/exc_arbiter.sv
// Writeback exception/interrupt arbiter: one registered CSR pulse per event,
// then a fixed-length flush window that blocks further commits.
module exc_arbiter
  import exc_arbiter_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int PC_W         = 32
) (
  input logic         clk,
  input logic         reset,
  exc_arbiter_if.slave bus
);

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            w_int_pend;
  logic            w_accept;
  logic            w_hit;
  logic [5:0]      w_excode;
  logic [8:0]      w_esubcode;
  logic [PC_W-1:0] w_badvaddr;
  event_t          w_event;

  assign w_int_pend = bus.ie & (|(bus.lie & bus.is));
  assign w_accept   = ~reset & (r_state == ST_IDLE) & bus.wb_valid;

  exc_prio_enc #(.PC_W(PC_W)) u_prio (
    .i_int_pend (w_int_pend),
    .i_exc      (bus.wb_exc),
    .i_badv     (bus.wb_badv),
    .i_pc       (bus.wb_pc),
    .o_hit      (w_hit),
    .o_excode   (w_excode),
    .o_esubcode (w_esubcode),
    .o_badvaddr (w_badvaddr)
  );

  always_comb begin
    w_event = EV_NONE;
    if (w_accept) begin
      if (w_hit)               w_event = EV_EXC;
      else if (bus.wb_is_ertn) w_event = EV_ERTN;
      else if (bus.wb_refetch) w_event = EV_REFETCH;
    end
  end

  assign bus.commit_ok = w_accept & ~w_hit;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; the counter counts the remaining flush cycles after this one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_event != EV_NONE) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = 4'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the registered state.
  always_comb begin
    bus.flush = (r_state == ST_FLUSH);
  end

  // CSR-facing pulses and payload; payload holds between events.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.is_exc         <= 1'b0;
      bus.is_ertn        <= 1'b0;
      bus.is_fetch_again <= 1'b0;
      bus.excode         <= '0;
      bus.esubcode       <= '0;
      bus.badvaddr       <= '0;
      bus.csr_pc         <= '0;
    end else begin
      bus.is_exc         <= (w_event == EV_EXC);
      bus.is_ertn        <= (w_event == EV_ERTN);
      bus.is_fetch_again <= (w_event == EV_REFETCH);
      if (w_event == EV_EXC) begin
        bus.excode   <= w_excode;
        bus.esubcode <= w_esubcode;
        bus.badvaddr <= w_badvaddr;
      end
      if (w_event != EV_NONE) begin
        bus.csr_pc <= (w_event == EV_REFETCH) ? bus.wb_pc + PC_W'(4) : bus.wb_pc;
      end
    end
  end

endmodule

// File: tb/tb_exc_arbiter.sv
// Bench for exc_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a priority-table reference model.
module tb_exc_arbiter;

  localparam int N = 2;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] pc;
    logic [31:0] badv;
    logic [13:0] exc;
    logic        ertn;
    logic        rf;
    logic [11:0] lie;
    logic [11:0] is_;
    logic        ie;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   armed = 0;

  always #5 clk = ~clk;

  exc_arbiter_if #(.PC_W(32)) bus ();

  exc_arbiter #(.FLUSH_CYCLES(N), .PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          rem = 0;            // flush cycles still to come
  logic        m_exc = 0, m_ertn = 0, m_fa = 0;
  logic [5:0]  m_code = 0;
  logic [8:0]  m_sub = 0;
  logic [31:0] m_badv = 0, m_pc = 0;

  // Per-bit table: excode, subcode, BADV source (0 none, 1 pc, 2 badv).
  function automatic void bit_info(input int b, input logic [31:0] badv,
                                   output logic [5:0] code, output logic [8:0] sub,
                                   output int src);
    sub = 9'd0;
    case (b)
      13: begin code = 6'h08; src = 1; end
      12: begin code = 6'h3F; src = 1; end
      11: begin code = 6'h03; src = 1; end
      10: begin code = 6'h07; src = 1; end
      9:  begin code = 6'h0D; src = 0; end
      8:  begin code = 6'h0E; src = 0; end
      7:  begin code = 6'h0B; src = 0; end
      6:  begin code = 6'h0C; src = 0; end
      5:  begin code = 6'h09; src = 2; end
      4:  begin code = 6'h08; sub = 9'd1; src = 2; end
      3:  begin code = 6'h3F; src = 2; end
      2:  begin code = 6'h01; src = 2; end
      1:  begin code = 6'h02; src = 2; end
      default: begin code = badv[31] ? 6'h07 : 6'h04; src = 2; end
    endcase
  endfunction

  always @(negedge clk) begin
    logic        ip, exc_any, exp_commit;
    logic [13:0] e;
    int          top, src;
    logic [5:0]  c;
    logic [8:0]  s;
    e          = bus.wb_exc;
    ip         = bus.ie && ((bus.lie & bus.is) != 12'd0);
    exc_any    = ip || (e != 14'd0);
    exp_commit = !reset && rem == 0 && bus.wb_valid && !exc_any;
    if (armed) begin
      check("commit_ok", 32'(bus.commit_ok), 32'(exp_commit));
      check("flush", 32'(bus.flush), 32'(rem > 0));
      check("is_exc", 32'(bus.is_exc), 32'(m_exc));
      check("is_ertn", 32'(bus.is_ertn), 32'(m_ertn));
      check("is_fetch_again", 32'(bus.is_fetch_again), 32'(m_fa));
      check("excode", 32'(bus.excode), 32'(m_code));
      check("esubcode", 32'(bus.esubcode), 32'(m_sub));
      check("badvaddr", bus.badvaddr, m_badv);
      check("csr_pc", bus.csr_pc, m_pc);
    end
    m_exc = 0; m_ertn = 0; m_fa = 0;
    if (reset) begin
      rem = 0; m_code = 0; m_sub = 0; m_badv = 0; m_pc = 0;
      armed = 1;
    end else if (rem == 0 && bus.wb_valid && (exc_any || bus.wb_is_ertn || bus.wb_refetch)) begin
      rem = N;
      if (exc_any) begin
        m_exc = 1;
        m_pc  = bus.wb_pc;
        if (ip) begin
          m_code = 6'h00; m_sub = 0; m_badv = 0;
        end else begin
          top = 0;
          for (int i = 0; i < 14; i++) if (e[i]) top = i;
          bit_info(top, bus.wb_badv, c, s, src);
          m_code = c; m_sub = s;
          m_badv = (src == 1) ? bus.wb_pc : (src == 2) ? bus.wb_badv : 32'd0;
        end
      end else if (bus.wb_is_ertn) begin
        m_ertn = 1; m_pc = bus.wb_pc;
      end else begin
        m_fa = 1; m_pc = bus.wb_pc + 32'd4;
      end
    end else if (rem > 0) begin
      rem--;
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input stim_t st);
    reset          = st.rst;
    bus.wb_valid   = st.v;
    bus.wb_pc      = st.pc;
    bus.wb_badv    = st.badv;
    bus.wb_exc     = st.exc;
    bus.wb_is_ertn = st.ertn;
    bus.wb_refetch = st.rf;
    bus.lie        = st.lie;
    bus.is         = st.is_;
    bus.ie         = st.ie;
  endtask

  // Drive just after a rising edge, return at the following falling edge.
  task automatic cyc(input stim_t st);
    @(posedge clk);
    #1;
    apply(st);
    @(negedge clk);
  endtask

  function automatic stim_t idle_st();
    stim_t st;
    st = '{rst: 0, v: 0, pc: 32'h0, badv: 32'h0, exc: 14'h0, ertn: 0, rf: 0,
           lie: 12'h0, is_: 12'h0, ie: 0};
    return st;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(idle_st());
  endtask

  initial begin
    stim_t st;
    st = idle_st();
    st.rst = 1; st.v = 1; st.exc = 14'h0080;
    apply(st);

    for (int i = 0; i < 3; i++) begin
      cyc(st);
      check("rst_commit_ok", 32'(bus.commit_ok), 32'd0);
      check("rst_is_exc", 32'(bus.is_exc), 32'd0);
      check("rst_flush", 32'(bus.flush), 32'd0);
    end
    idle(2);

    // SYS exception, then an instruction arriving during the flush
    st = idle_st(); st.v = 1; st.pc = 32'h1c000100; st.exc = 14'h0080;
    cyc(st);
    check("sys_commit_ok", 32'(bus.commit_ok), 32'd0);
    st = idle_st(); st.v = 1; st.pc = 32'h1c000104;
    cyc(st);
    check("sys_is_exc", 32'(bus.is_exc), 32'd1);
    check("sys_excode", 32'(bus.excode), 32'h0B);
    check("sys_csr_pc", bus.csr_pc, 32'h1c000100);
    check("sys_badv", bus.badvaddr, 32'h0);
    check("sys_flush1", 32'(bus.flush), 32'd1);
    check("sys_blocked", 32'(bus.commit_ok), 32'd0);
    idle(1);
    check("sys_flush2", 32'(bus.flush), 32'd1);
    idle(1);
    check("sys_flush_end", 32'(bus.flush), 32'd0);

    // Priority: ADEF wins over TLBR-fetch and ALE; then INT wins over all
    st = idle_st(); st.v = 1; st.pc = 32'h1c000102; st.badv = 32'h0000_1234; st.exc = 14'h3020;
    cyc(st);
    idle(1);
    check("prio_excode", 32'(bus.excode), 32'h08);
    check("prio_esub", 32'(bus.esubcode), 32'h0);
    check("prio_badv", bus.badvaddr, 32'h1c000102);
    idle(2);
    st.ie = 1; st.lie = 12'h800; st.is_ = 12'h800;
    cyc(st);
    idle(1);
    check("int_excode", 32'(bus.excode), 32'h00);
    check("int_is_exc", 32'(bus.is_exc), 32'd1);
    idle(2);

    // Refetch with PC wrap
    st = idle_st(); st.v = 1; st.rf = 1; st.pc = 32'hFFFFFFFC;
    cyc(st);
    check("rf_commit_ok", 32'(bus.commit_ok), 32'd1);
    idle(1);
    check("rf_pulse", 32'(bus.is_fetch_again), 32'd1);
    check("rf_csr_pc", bus.csr_pc, 32'h0);
    check("rf_flush", 32'(bus.flush), 32'd1);
    idle(2);

    // ERTN alone, then ERTN with a pending interrupt
    st = idle_st(); st.v = 1; st.ertn = 1; st.pc = 32'h1c000200; st.lie = 12'h001; st.is_ = 12'h001;
    cyc(st);
    check("ertn_commit_ok", 32'(bus.commit_ok), 32'd1);
    idle(1);
    check("ertn_pulse", 32'(bus.is_ertn), 32'd1);
    idle(2);
    st.ie = 1;
    cyc(st);
    check("ertn_int_commit", 32'(bus.commit_ok), 32'd0);
    idle(1);
    check("ertn_int_exc", 32'(bus.is_exc), 32'd1);
    check("ertn_int_ertn", 32'(bus.is_ertn), 32'd0);
    check("ertn_int_code", 32'(bus.excode), 32'h00);
    idle(2);

    // Back-to-back events, then reset during the flush
    st = idle_st(); st.v = 1; st.exc = 14'h0040; st.pc = 32'h1c000300;
    cyc(st);
    st.pc = 32'h1c000304;
    cyc(st);
    check("b2b_csr_pc", bus.csr_pc, 32'h1c000300);
    idle(2);
    check("b2b_no_second", 32'(bus.is_exc), 32'd0);
    st = idle_st(); st.v = 1; st.exc = 14'h0080; st.pc = 32'h1c000400;
    cyc(st);
    st = idle_st(); st.rst = 1;
    cyc(st);
    check("mrst_is_exc_t1", 32'(bus.is_exc), 32'd1);
    idle(1);
    check("mrst_is_exc_t2", 32'(bus.is_exc), 32'd0);
    check("mrst_flush_t2", 32'(bus.flush), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      st = idle_st();
      st.rst  = ($urandom_range(0, 199) == 0);
      st.v    = ($urandom_range(0, 3) != 0);
      st.pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
      st.badv = $urandom;
      case ($urandom_range(0, 5))
        0:       st.exc = 14'($urandom);
        1, 2:    st.exc = 14'(1) << $urandom_range(0, 13);
        default: st.exc = 14'h0;
      endcase
      st.ertn = ($urandom_range(0, 5) == 0);
      st.rf   = ($urandom_range(0, 5) == 0);
      st.lie  = 12'($urandom);
      st.is_  = ($urandom_range(0, 5) == 0) ? 12'($urandom) : 12'h0;
      st.ie   = 1'($urandom);
      cyc(st);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
